instr_fifo: RTL

Parametrised instruction FIFO that replaces the fixed four-stage `data_buffer` chain between the QSPI controller and the instruction decoder in the VGA video player. It holds DEPTH words of WIDTH bits and presents the head word in first-word-fall-through form. It drives a hysteresis refill request, so the QSPI controller can pause and resume streaming instead of shifting on every transfer. It also flags overflow (a write dropped while full) and underflow (the decoder starved) with sticky status bits.

---
 rtl/instr_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_fifo.sv
// First-word-fall-through instruction FIFO between the QSPI controller and the decoder.
// Drives a hysteresis refill request and keeps sticky overflow/underflow status.
module instr_fifo #(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOW_MARK  = 1,
  parameter int unsigned HIGH_MARK = DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       refill_req,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } refill_state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  refill_state_e  state_q, state_d;
  logic           push;
  logic           pop;

  // Handshake flags decode registered state only (plus reset/flush gating on wr_ready).
  assign wr_ready = (level_q != LW'(DEPTH)) & rst_n & ~flush;
  assign rd_valid = (level_q != LW'(0));
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready & ~flush;

  assign rd_data    = mem[rd_ptr_q];
  assign level      = level_q;
  assign refill_req = (state_q == ST_FILL);
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  // Storage array; no reset since contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Next-state for pointers, occupancy, sticky flags and the refill machine.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    state_d  = state_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      state_d  = ST_FILL;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (wr_valid & ~wr_ready);
      unf_d = unf_q | (rd_ready & ~rd_valid);

      // Hysteresis is judged on the next level so refill_req tracks level edge-for-edge.
      case (state_q)
        ST_FILL: if (level_d >= LW'(HIGH_MARK)) state_d = ST_HOLD;
        ST_HOLD: if (level_d <= LW'(LOW_MARK))  state_d = ST_FILL;
        default: state_d = ST_FILL;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      state_q  <= ST_FILL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      state_q  <= state_d;
    end
  end

endmodule
